uart_host_bridge: RTL and testbench

UART_HOST_BRIDGE -- requirements
Module: uart_host_bridge

---
 rtl/host_bridge_pkg.sv | 42 ++++
 rtl/word_byte_shifter.sv | 44 ++++
 rtl/uart_host_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_host_bridge.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/host_bridge_pkg.sv
// Shared definitions for the UART host bridge: FSM state encoding, host command codes,
// status bytes and the memory-request ctrl-byte layout.
package host_bridge_pkg;

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      RESET_CPU  = 4'd1,
      SEND_READY = 4'd2,
      CMD        = 4'd3,
      RX_CNT     = 4'd4,
      RX_INSTR   = 4'd5,
      EXEC       = 4'd6,
      SEND_ADDR  = 4'd7,
      SEND_CTRL  = 4'd8,
      WAIT_DATA  = 4'd9,
      SEND_WDATA = 4'd10,
      STEP       = 4'd11,
      SEND_PC    = 4'd12,
      SEND_ERR   = 4'd13
   } state_t;

   localparam logic [7:0] CMD_RESET  = 8'h01;
   localparam logic [7:0] CMD_PC     = 8'h02;
   localparam logic [7:0] CMD_STEP   = 8'h03;
   localparam logic [7:0] CMD_RUN_N  = 8'h04;
   localparam logic [7:0] BYTE_READY = 8'h01;
   localparam logic [7:0] BYTE_ERR   = 8'hEE;

   localparam logic [1:0] CTRL_TAG_WR = 2'b01;
   localparam logic [1:0] CTRL_TAG_RD = 2'b10;

   function automatic logic [7:0] ctrl_byte(input logic       wr,
                                            input logic [1:0] mem_write,
                                            input logic [2:0] size_load);
      return wr ? {CTRL_TAG_WR, 4'b0000, mem_write} : {CTRL_TAG_RD, 3'b000, size_load};
   endfunction

   function automatic logic is_tx_state(input state_t s);
      return s inside {SEND_READY, SEND_ADDR, SEND_CTRL, SEND_WDATA, SEND_PC, SEND_ERR};
   endfunction

endpackage

// File: rtl/word_byte_shifter.sv
// Word <-> byte shifter: serialises a loaded word LSB first and assembles received bytes LSB first.
// Latency: load/shift/rx take effect next cycle; word_nxt is combinational with the incoming byte.
// Backpressure: none internally; the caller only strobes shift on an accepted tx byte.
module word_byte_shifter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [XLEN-1:0] load_word,
   input  logic            shift,
   input  logic            rx,
   input  logic [7:0]      rx_byte,
   input  logic [3:0]      last_idx,
   output logic [7:0]      byte_out,
   output logic [XLEN-1:0] word_nxt,
   output logic            last
);

   logic [XLEN-1:0] sr;
   logic [3:0]      idx;

   assign byte_out = sr[7:0];
   assign word_nxt = {rx_byte, sr[XLEN-1:8]};
   assign last     = (idx == last_idx);

   // The index wraps to zero after the final byte so every word starts aligned.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr  <= '0;
         idx <= '0;
      end else if (load) begin
         sr  <= load_word;
         idx <= '0;
      end else if (shift) begin
         sr  <= sr >> 8;
         idx <= last ? 4'd0 : idx + 4'd1;
      end else if (rx) begin
         sr  <= word_nxt;
         idx <= last ? 4'd0 : idx + 4'd1;
      end
   end

endmodule

// File: rtl/uart_host_bridge.sv
// UART host bridge: steps a CPU under host control and forwards its memory accesses over a byte link.
// Latency: one idle cycle before each tx field; cpu_reset/cpu_run are registered single-cycle pulses.
// Backpressure: tx bytes held until tx_ready; rx never stalled. HOST_BRIDGE_TIMEOUT_EN adds an rx timeout.
module uart_host_bridge
   import host_bridge_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_valid,
   input  logic [7:0]      rx_byte,
   output logic            tx_valid,
   output logic [7:0]      tx_byte,
   input  logic            tx_ready,
   output logic            cpu_reset,
   output logic            cpu_run,
   output logic [XLEN-1:0] instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] address,
   input  logic [XLEN-1:0] writeData,
   input  logic            write_enable,
   input  logic            read_enable,
   input  logic [1:0]      MemWrite,
   input  logic [2:0]      SizeLoad,
   output logic [XLEN-1:0] readData,
   output logic [3:0]      state_dbg,
   output logic            err_sticky
);

   localparam int NB    = XLEN / 8;
   localparam int CNT_B = (CNT_W + 7) / 8;

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("uart_host_bridge: XLEN must be 32 or 64");
   end
   if (CNT_W < 2 || CNT_W > XLEN || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("uart_host_bridge: CNT_W must be 2..XLEN and TIMEOUT_CYC positive");
   end

   state_t            state;
   logic              is_wr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  cnt_dec;
   logic [CNT_B*8-1:0] cnt_raw;

   logic              tx_state, rx_state;
   logic              sh_load, sh_rx, sh_last, tx_acc, tx_done;
   logic [3:0]        last_idx;
   logic [XLEN-1:0]   sh_word, word_nxt;
   logic              tmo_hit;

   assign tx_state  = is_tx_state(state);
   assign rx_state  = (state == RX_CNT) || (state == RX_INSTR) || (state == WAIT_DATA);
   assign sh_load   = tx_state & ~tx_valid;
   assign tx_acc    = tx_state & tx_valid & tx_ready;
   assign tx_done   = tx_acc & sh_last;
   assign sh_rx     = rx_state & rx_valid;
   assign cnt_raw   = word_nxt[XLEN-1 -: CNT_B*8];
   assign cnt_dec   = count - 1'b1;
   assign state_dbg = state;

   // Word to serialise on entry to each tx state, and the byte index that ends the current field.
   always_comb begin
      sh_word  = '0;
      last_idx = 4'(NB - 1);
      case (state)
         SEND_READY: begin
            sh_word  = {{(XLEN-8){1'b0}}, BYTE_READY};
            last_idx = 4'd0;
         end
         SEND_ERR: begin
            sh_word  = {{(XLEN-8){1'b0}}, BYTE_ERR};
            last_idx = 4'd0;
         end
         SEND_CTRL: begin
            sh_word  = {{(XLEN-8){1'b0}}, ctrl_byte(is_wr, MemWrite, SizeLoad)};
            last_idx = 4'd0;
         end
         SEND_ADDR:  sh_word = address;
         SEND_WDATA: sh_word = writeData;
         SEND_PC:    sh_word = pc;
         RX_CNT:     last_idx = 4'(CNT_B - 1);
         default:    ;
      endcase
   end

   word_byte_shifter #(.XLEN(XLEN)) u_shifter (
      .clk       (clk),
      .reset     (reset),
      .load      (sh_load),
      .load_word (sh_word),
      .shift     (tx_acc),
      .rx        (sh_rx),
      .rx_byte   (rx_byte),
      .last_idx  (last_idx),
      .byte_out  (tx_byte),
      .word_nxt  (word_nxt),
      .last      (sh_last)
   );

`ifdef HOST_BRIDGE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt;

   assign tmo_hit = rx_state & ~rx_valid & (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= '0;
      end else if (!rx_state || rx_valid || tmo_hit) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         tx_valid   <= 1'b0;
         cpu_reset  <= 1'b0;
         cpu_run    <= 1'b0;
         instr      <= '0;
         readData   <= '0;
         count      <= '0;
         err_sticky <= 1'b0;
         is_wr      <= 1'b0;
      end else begin
         cpu_reset <= 1'b0;
         cpu_run   <= 1'b0;
         // A tx state raises valid the cycle after entry and drops it on the field's last handshake.
         if (sh_load) tx_valid <= 1'b1;
         if (tx_done) tx_valid <= 1'b0;

         case (state)
            IDLE: begin
               cpu_reset <= 1'b1;
               state     <= RESET_CPU;
            end
            RESET_CPU: state <= SEND_READY;
            SEND_READY: if (tx_done) state <= CMD;
            CMD: begin
               if (rx_valid) begin
                  case (rx_byte)
                     CMD_RESET: begin
                        cpu_reset <= 1'b1;
                        state     <= RESET_CPU;
                     end
                     CMD_PC: state <= SEND_PC;
                     CMD_STEP: begin
                        count <= {{(CNT_W-1){1'b0}}, 1'b1};
                        state <= RX_INSTR;
                     end
                     CMD_RUN_N: state <= RX_CNT;
                     default:   state <= SEND_ERR;
                  endcase
               end
            end
            RX_CNT: begin
               if (tmo_hit) begin
                  state <= SEND_ERR;
               end else if (sh_rx && sh_last) begin
                  count <= cnt_raw[CNT_W-1:0];
                  state <= (cnt_raw[CNT_W-1:0] == '0) ? SEND_READY : RX_INSTR;
               end
            end
            RX_INSTR: begin
               if (tmo_hit) begin
                  state <= SEND_ERR;
               end else if (sh_rx && sh_last) begin
                  instr <= word_nxt;
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (write_enable || read_enable) begin
                  is_wr <= write_enable;
                  state <= SEND_ADDR;
               end else begin
                  cpu_run <= 1'b1;
                  state   <= STEP;
               end
            end
            SEND_ADDR: if (tx_done) state <= SEND_CTRL;
            SEND_CTRL: if (tx_done) state <= is_wr ? SEND_WDATA : WAIT_DATA;
            WAIT_DATA: begin
               // On timeout the CPU still gets its step, with a zero load result.
               if (tmo_hit) begin
                  readData <= '0;
                  cpu_run  <= 1'b1;
                  state    <= SEND_ERR;
               end else if (sh_rx && sh_last) begin
                  readData <= word_nxt;
                  cpu_run  <= 1'b1;
                  state    <= STEP;
               end
            end
            SEND_WDATA: begin
               if (tx_done) begin
                  cpu_run <= 1'b1;
                  state   <= STEP;
               end
            end
            STEP: begin
               count <= cnt_dec;
               state <= (cnt_dec == '0) ? SEND_READY : RX_INSTR;
            end
            SEND_PC: if (tx_done) state <= SEND_READY;
            SEND_ERR: begin
               err_sticky <= 1'b1;
               if (tx_done) state <= SEND_READY;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge: boot, single step, write/read forwarding, RUN_N, errors, reset abort.
// Drives inputs on the falling edge and samples outputs there; the timeout case runs when HOST_BRIDGE_TIMEOUT_EN is defined.
module tb_uart_host_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx_valid, tx_valid, tx_ready;
   logic [7:0]  rx_byte, tx_byte;
   logic        cpu_reset, cpu_run, write_enable, read_enable, err_sticky;
   logic [31:0] instr, pc, address, writeData, readData;
   logic [1:0]  MemWrite;
   logic [2:0]  SizeLoad;
   logic [3:0]  state_dbg;

   int n_checks = 0;
   int n_pass = 0;
   int run_pulses = 0;
   int rst_pulses = 0;
   int r0;

   always #5 clk = ~clk;

   uart_host_bridge #(.XLEN(32), .CNT_W(16), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .reset(reset),
      .rx_valid(rx_valid), .rx_byte(rx_byte),
      .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
      .cpu_reset(cpu_reset), .cpu_run(cpu_run), .instr(instr),
      .pc(pc), .address(address), .writeData(writeData),
      .write_enable(write_enable), .read_enable(read_enable),
      .MemWrite(MemWrite), .SizeLoad(SizeLoad),
      .readData(readData), .state_dbg(state_dbg), .err_sticky(err_sticky)
   );

   // High cycles of each pulse output; a pulse stretched past one cycle shows up as an extra count.
   always @(negedge clk) begin
      if (cpu_run)   run_pulses++;
      if (cpu_reset) rst_pulses++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_rx(w[8*i +: 8]);
   endtask

   task automatic expect_tx(input string tag, input logic [7:0] exp, input int hold);
      int w = 0;
      while (!tx_valid && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk(tag, {55'd0, tx_valid, tx_byte}, {55'd0, 1'b1, exp});
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         chk({tag, "_hold"}, {55'd0, tx_valid, tx_byte}, {55'd0, 1'b1, exp});
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
   endtask

   task automatic expect_word(input string tag, input logic [31:0] w);
      for (int i = 0; i < 4; i++) expect_tx($sformatf("%s%0d", tag, i), w[8*i +: 8], 0);
   endtask

   task automatic wait_state(input string tag, input logic [3:0] s);
      int w = 0;
      while (state_dbg !== s && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk(tag, {60'd0, state_dbg}, {60'd0, s});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b0;
      pc = '0; address = '0; writeData = '0;
      write_enable = 1'b0; read_enable = 1'b0; MemWrite = 2'd0; SizeLoad = 3'd0;

      repeat (3) @(negedge clk);
      chk("rst_state", {60'd0, state_dbg}, 64'd0);
      chk("rst_txv", {63'd0, tx_valid}, 64'd0);
      chk("rst_pulses_lo", {62'd0, cpu_run, cpu_reset}, 64'd0);
      chk("rst_instr", {32'd0, instr}, 64'd0);
      chk("rst_rdata", {32'd0, readData}, 64'd0);
      chk("rst_err", {63'd0, err_sticky}, 64'd0);

      // Boot: one cpu_reset pulse then the ready byte.
      reset = 1'b1;
      expect_tx("boot_ready", 8'h01, 0);
      chk("boot_rst_pulse", 64'(rst_pulses), 64'd1);

      // Single step with no memory access.
      r0 = run_pulses;
      send_rx(8'h03);
      send_word(32'h00500093);
      expect_tx("step_ready", 8'h01, 0);
      chk("step_instr", {32'd0, instr}, 64'h00500093);
      chk("step_runs", 64'(run_pulses - r0), 64'd1);

      // Store, with read_enable also high: write wins. Ctrl byte held under backpressure.
      write_enable = 1'b1; read_enable = 1'b1;
      address = 32'h100; MemWrite = 2'd2; writeData = 32'hDEADBEEF;
      r0 = run_pulses;
      send_rx(8'h03);
      send_word(32'h00112023);
      expect_word("wr_addr", 32'h00000100);
      expect_tx("wr_ctrl", 8'h42, 3);
      expect_word("wr_data", 32'hDEADBEEF);
      expect_tx("wr_ready", 8'h01, 0);
      chk("wr_runs", 64'(run_pulses - r0), 64'd1);

      // RUN_N with count 3, every step a load answered by the host.
      write_enable = 1'b0; read_enable = 1'b1;
      address = 32'h200; SizeLoad = 3'd2;
      r0 = run_pulses;
      send_rx(8'h04);
      send_rx(8'h03);
      send_rx(8'h00);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) wait_state($sformatf("rd_rx_instr%0d", i), 4'd5);
         send_word(32'h00012103);
         expect_word($sformatf("rd%0d_addr", i), 32'h00000200);
         expect_tx($sformatf("rd%0d_ctrl", i), 8'h82, 0);
         send_word(32'h11223344);
      end
      expect_tx("rd_ready", 8'h01, 0);
      chk("rd_rdata", {32'd0, readData}, 64'h11223344);
      chk("rd_runs", 64'(run_pulses - r0), 64'd3);
      chk("rd_instr", {32'd0, instr}, 64'h00012103);

      // RUN_N with count 0 executes nothing; instr/readData keep their values.
      r0 = run_pulses;
      send_rx(8'h04);
      send_rx(8'h00);
      send_rx(8'h00);
      expect_tx("cnt0_ready", 8'h01, 0);
      chk("cnt0_runs", 64'(run_pulses - r0), 64'd0);
      chk("cnt0_rdata_hold", {32'd0, readData}, 64'h11223344);
      chk("cnt0_instr_hold", {32'd0, instr}, 64'h00012103);

      // Reset while the store data is on the wire.
      write_enable = 1'b1; read_enable = 1'b0; address = 32'h100;
      send_rx(8'h03);
      send_word(32'h00112023);
      expect_word("ab_addr", 32'h00000100);
      expect_tx("ab_ctrl", 8'h42, 0);
      wait_state("ab_wdata_state", 4'd10);
      @(negedge clk);
      chk("ab_wdata_vld", {55'd0, tx_valid, tx_byte}, {55'd0, 1'b1, 8'hEF});
      reset = 1'b0;
      #1;
      chk("ab_txv", {63'd0, tx_valid}, 64'd0);
      chk("ab_state", {60'd0, state_dbg}, 64'd0);
      r0 = rst_pulses;
      @(negedge clk);
      reset = 1'b1;
      write_enable = 1'b0;
      expect_tx("reboot_ready", 8'h01, 0);
      chk("reboot_rst_pulse", 64'(rst_pulses - r0), 64'd1);

      // Unknown command.
      send_rx(8'h7F);
      expect_tx("err_ee", 8'hEE, 0);
      expect_tx("err_ready", 8'h01, 0);
      chk("err_sticky", {63'd0, err_sticky}, 64'd1);

      // PC readback; the error flag stays set.
      pc = 32'hCAFEF00D;
      send_rx(8'h02);
      expect_word("pc", 32'hCAFEF00D);
      expect_tx("pc_ready", 8'h01, 0);
      chk("err_sticky_hold", {63'd0, err_sticky}, 64'd1);

`ifdef HOST_BRIDGE_TIMEOUT_EN
      // Host silent in WAIT_DATA: zero load result, one step, then the error byte.
      read_enable = 1'b1; address = 32'h200; SizeLoad = 3'd2;
      r0 = run_pulses;
      send_rx(8'h03);
      send_word(32'h00012103);
      expect_word("tmo_addr", 32'h00000200);
      expect_tx("tmo_ctrl", 8'h82, 0);
      expect_tx("tmo_ee", 8'hEE, 0);
      chk("tmo_rdata", {32'd0, readData}, 64'd0);
      chk("tmo_runs", 64'(run_pulses - r0), 64'd1);
      expect_tx("tmo_ready", 8'h01, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
